// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin packet-locked N:1 mux with registered output; `define MUX_ARB_TIMEOUT_EN adds an idle-grant timeout
module mux_arbiter #(
  parameter int N = 4,
  parameter int W = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [N*W-1:0]       req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_ready,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 busy
`ifdef MUX_ARB_TIMEOUT_EN
  ,
  output logic                 timeout_pulse
`endif
);
  localparam int GW = $clog2(N);
  localparam logic [0:0] IDLE = 1'b0, LOCKED = 1'b1;
  if (N < 2 || (N & (N - 1)) != 0 || TIMEOUT < 1) begin : g_bad
    $error("mux_arbiter: N must be a power of two >= 2 and TIMEOUT >= 1");
  end
  logic [0:0]    state;
  logic [GW-1:0] ptr, winner;
  logic          accept, tmo;
  always_comb begin
    winner = ptr;
    for (int k = N - 1; k >= 0; k--)
      if (req_valid[ptr + GW'(k)]) winner = ptr + GW'(k);
  end
  assign busy      = state == LOCKED;
  assign req_ready = (rst && busy && (!out_valid || out_ready)) ? N'(1) << grant_idx : '0;
  assign accept    = req_valid[grant_idx] && req_ready[grant_idx];
`ifdef MUX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign tmo = rst && busy && !req_valid[grant_idx] && cnt == CW'(TIMEOUT - 1);
  assign timeout_pulse = tmo;
  always_ff @(posedge clk)
    cnt <= (!rst || !busy || accept) ? '0 : cnt + CW'(!req_valid[grant_idx]);
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_idx <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= req_data[grant_idx*W +: W];
        out_last  <= req_last[grant_idx];
      end else if (out_ready) out_valid <= 1'b0;
      if (state == IDLE) begin
        if (|req_valid) begin
          grant_idx <= winner;
          state     <= LOCKED;
        end
      end else if ((accept && req_last[grant_idx]) || tmo) begin
        state <= IDLE;
        ptr   <= grant_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: randomized packet streams checked against a packet-level round-robin scoreboard
module tb_mux_arbiter;
  localparam int N = 4, W = 32, CAP = 512;
  typedef struct packed {logic [W-1:0] d; logic l;} beat_t;
  logic clk = 0, rst = 0;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [N*W-1:0] req_data = '0;
  logic out_valid, out_last, out_ready = 1'b0, busy;
  logic [W-1:0] out_data;
  logic [1:0] grant_idx;
`ifdef MUX_ARB_TIMEOUT_EN
  logic timeout_pulse;
`endif
  always #5 clk = ~clk;
  mux_arbiter #(.N(N), .W(W), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .grant_idx(grant_idx), .busy(busy)
`ifdef MUX_ARB_TIMEOUT_EN
    , .timeout_pulse(timeout_pulse)
`endif
  );
  int checks = 0, errors = 0;
  logic [W-1:0] sd [N][CAP];
  logic         sl [N][CAP];
  int head [N], tail [N];
  beat_t expq [$];
  int m_ptr = 0, m_g = 0;
  bit m_busy = 0;
  int valid_pct = 100, ready_pct = 100;
  int order [5] = '{0, 1, 2, 3, 0};
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic push(input int i, input logic [W-1:0] d, input logic l);
    sd[i][tail[i]] = d;
    sl[i][tail[i]] = l;
    tail[i]++;
  endtask
  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += tail[i] - head[i];
    return s;
  endfunction
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bit has = tail[i] > head[i];
      req_valid[i] = has && ($urandom_range(99) < valid_pct);
      req_data[i*W +: W] = has ? sd[i][head[i]] : W'($urandom);
      req_last[i] = has ? sl[i][head[i]] : 1'($urandom);
    end
    out_ready = $urandom_range(99) < ready_pct;
  endtask
  task automatic step();
    logic [N-1:0] fired, mask;
    beat_t b;
    int w = 0;
    bit arb = 0;
    drive();
    @(negedge clk);
    fired = req_valid & req_ready;
    mask = m_busy ? N'(1) << m_g : '0;
    check("busy", busy, m_busy);
    check("ready_onehot", $countones(req_ready) <= 1, 1);
    check("ready_mask", req_ready & ~mask, 0);
    if (m_busy && out_ready) check("ready_free", req_ready[m_g], 1);
    if (out_valid) begin
      check("out_pending", expq.size() > 0, 1);
      if (expq.size() > 0) begin
        check("out_data", out_data, expq[0].d);
        check("out_last", out_last, expq[0].l);
        if (out_ready) void'(expq.pop_front());
      end
    end
    if (m_busy) begin
      if (fired[m_g]) begin
        if (sl[m_g][head[m_g]]) m_busy = 0;
        head[m_g]++;
      end
    end else if (|req_valid) begin
      arb = 1;
      for (int k = 0; k < N; k++)
        if (req_valid[(m_ptr + k) % N]) begin
          w = (m_ptr + k) % N;
          break;
        end
      for (int j = head[w]; j < tail[w]; j++) begin
        b.d = sd[w][j];
        b.l = sl[w][j];
        expq.push_back(b);
        if (sl[w][j]) break;
      end
      m_busy = 1;
      m_g = w;
      m_ptr = (w + 1) % N;
    end
    @(posedge clk);
    #1;
    if (arb) check("grant", grant_idx, w);
  endtask
  initial begin
    int guard;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_idx, 0);
    check("rst_out_data", out_data, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) push(i, 32'h300 + i, 1'b1);
    push(0, 32'h304, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_grant", grant_idx, order[k]);
      step();
      check("rr_out_valid", out_valid, 1);
      check("rr_busy", busy, 0);
    end
    push(2, 32'hA0, 0); push(2, 32'hA1, 0); push(2, 32'hA2, 1);
    step();
    check("pkt_grant", grant_idx, 2);
    check("pkt_busy", busy, 1);
    check("pkt_no_beat", out_valid, 0);
    step();
    check("pkt_d0", out_data, 32'hA0);
    check("pkt_v0", out_valid, 1);
    step();
    check("pkt_d1", out_data, 32'hA1);
    check("pkt_l1", out_last, 0);
    step();
    check("pkt_d2", out_data, 32'hA2);
    check("pkt_l2", out_last, 1);
    check("pkt_busy_fall", busy, 0);
    step();
    check("pkt_drained", out_valid, 0);
    for (int j = 0; j < 4; j++) push(1, 32'hB0 + j, j == 3);
    step();
    step();
    check("bp_first", out_data, 32'hB0);
    ready_pct = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 32'hB0);
      check("bp_ready", req_ready[1], 0);
    end
    ready_pct = 100;
    step();
    check("bp_next", out_data, 32'hB1);
    repeat (3) step();
    push(3, 32'hC0, 0); push(3, 32'hC1, 0); push(3, 32'hC2, 1);
    step();
    check("mid_grant", grant_idx, 3);
    step();
    push(0, 32'hD0, 1);
    drive();
    rst = 0;
    @(negedge clk);
    check("rst_mid_ready", req_ready, 0);
    @(posedge clk);
    #1 rst = 1;
    expq.delete();
    m_busy = 0;
    m_ptr = 0;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_grant", grant_idx, 0);
    step();
    check("rst_mid_winner", grant_idx, 0);
    for (int p = 0; p < 40; p++) begin
      int i = $urandom_range(N - 1);
      int len = $urandom_range(1, 4);
      for (int j = 0; j < len; j++) push(i, W'($urandom), j == len - 1);
    end
    valid_pct = 70;
    ready_pct = 70;
    repeat (400) step();
    valid_pct = 100;
    ready_pct = 100;
    guard = 0;
    while ((pending() > 0 || expq.size() > 0 || m_busy) && guard < 2000) begin
      step();
      guard++;
    end
    check("drain_left", pending() + expq.size(), 0);
`ifdef MUX_ARB_TIMEOUT_EN
    rst = 0;
    req_valid = '0;
    @(posedge clk);
    #1 rst = 1;
    req_valid = 4'b0011;
    req_last = 4'b0010;
    req_data[0 +: W] = 32'h55;
    req_data[W +: W] = 32'h66;
    out_ready = 1;
    @(posedge clk);
    #1 check("to_grant0", grant_idx, 0);
    @(posedge clk);
    #1 req_valid = 4'b0010;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("to_pulse", timeout_pulse, k == 16);
      check("to_no_last", out_last, 0);
      @(posedge clk);
      #1;
    end
    check("to_idle", busy, 0);
    @(posedge clk);
    #1 check("to_grant1", grant_idx, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
